// File: rtl/fifo_adc_stream_ctrl.sv
// ADC sample FIFO sequencer: write gating, AXI-Stream framing with TLAST, overflow flag.
// Optional dropped-sample counter port DropCnt_o when FIFO_ADC_DROP_CNT_EN is defined.
module fifo_adc_stream_ctrl #(
    parameter int FRAME_LEN_W = 16,
    parameter int CNT_W       = 32
) (
    input  logic                   Clk_i,
    input  logic                   Rst_n_i,
    input  logic                   Enable_i,
    input  logic [FRAME_LEN_W-1:0] FrameLen_i,
    input  logic                   AdcValid_i,
    input  logic                   FifoFull_i,
    input  logic                   FifoEmpty_i,
    input  logic                   AxisReady_i,
    input  logic                   OvfClr_i,
    output logic                   FifoWriteEn_o,
    output logic                   FifoReadEn_o,
    output logic                   AxisValid_o,
    output logic                   AxisLast_o,
    output logic                   Overflow_o,
    output logic                   Busy_o,
    output logic [CNT_W-1:0]       FrameCnt_o
`ifdef FIFO_ADC_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]       DropCnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_STOPPING
    } state_t;

    localparam logic [FRAME_LEN_W-1:0] ONE_LEN = FRAME_LEN_W'(1);
    localparam logic [CNT_W-1:0]       ONE_CNT = CNT_W'(1);

    state_t                 r_state;
    logic [FRAME_LEN_W-1:0] r_len;
    logic [FRAME_LEN_W-1:0] r_wr_cnt;
    logic [FRAME_LEN_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0]       r_frame_cnt;
    logic                   r_ovf;

    logic                   w_active;
    logic                   w_wr;
    logic                   w_drop;
    logic                   w_rd;
    logic                   w_drained;
    logic                   w_start;
    logic                   w_wr_last;
    logic                   w_rd_last;
    logic [FRAME_LEN_W-1:0] w_last_idx;
    logic [FRAME_LEN_W-1:0] w_len_eff;

    assign w_active   = (r_state == S_CAPTURE) | (r_state == S_STOPPING);
    assign w_wr       = w_active & AdcValid_i & ~FifoFull_i;
    assign w_drop     = w_active & AdcValid_i & FifoFull_i;
    assign w_rd       = ~FifoEmpty_i & AxisReady_i;
    assign w_drained  = FifoEmpty_i & (r_rd_cnt == '0);
    assign w_start    = (r_state == S_IDLE) & Enable_i & w_drained;
    // A zero length request degenerates to single-beat frames.
    assign w_len_eff  = (FrameLen_i == '0) ? ONE_LEN : FrameLen_i;
    assign w_last_idx = r_len - ONE_LEN;
    assign w_wr_last  = w_wr & (r_wr_cnt == w_last_idx);
    assign w_rd_last  = r_rd_cnt == w_last_idx;

    assign FifoWriteEn_o = w_wr;
    assign AxisValid_o   = ~FifoEmpty_i;
    assign FifoReadEn_o  = w_rd;
    assign AxisLast_o    = ~FifoEmpty_i & w_rd_last;
    assign Overflow_o    = r_ovf;
    assign Busy_o        = (r_state != S_IDLE) | ~w_drained;
    assign FrameCnt_o    = r_frame_cnt;

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            r_state <= S_IDLE;
            r_len   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_CAPTURE;
                        r_len   <= w_len_eff;
                    end
                end
                S_CAPTURE: begin
                    if (!Enable_i) begin
                        if (r_wr_cnt == '0 || w_wr_last)
                            r_state <= S_IDLE;
                        else
                            r_state <= S_STOPPING;
                    end
                end
                S_STOPPING: begin
                    if (w_wr_last)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            r_wr_cnt    <= '0;
            r_frame_cnt <= '0;
        end else if (w_start) begin
            r_wr_cnt    <= '0;
            r_frame_cnt <= '0;
        end else if (w_wr) begin
            r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + ONE_LEN;
            if (w_wr_last)
                r_frame_cnt <= r_frame_cnt + ONE_CNT;
        end
    end

    // Read beats are counted against the same latched length, so TLAST tracks write frames.
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i)
            r_rd_cnt <= '0;
        else if (w_rd)
            r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + ONE_LEN;
    end

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
        else if (OvfClr_i)
            r_ovf <= 1'b0;
    end

`ifdef FIFO_ADC_DROP_CNT_EN
    logic [CNT_W-1:0] r_drop_cnt;

    assign DropCnt_o = r_drop_cnt;

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i)
            r_drop_cnt <= '0;
        else if (OvfClr_i || w_start)
            r_drop_cnt <= '0;
        else if (w_drop && !(&r_drop_cnt))
            r_drop_cnt <= r_drop_cnt + ONE_CNT;
    end
`else
`endif

endmodule

// File: tb/tb_fifo_adc_stream_ctrl.sv
// Scoreboard bench for fifo_adc_stream_ctrl with a behavioural FWFT FIFO model.
// Expected TLAST per written sample is queued at write time and checked on each beat.
module tb_fifo_adc_stream_ctrl;

    localparam int FLW   = 16;
    localparam int CW    = 32;
    localparam int DEPTH = 32;

    logic           Clk_i = 1'b0;
    logic           Rst_n_i;
    logic           Enable_i;
    logic [FLW-1:0] FrameLen_i;
    logic           AdcValid_i;
    logic           FifoFull_i;
    logic           FifoEmpty_i;
    logic           AxisReady_i;
    logic           OvfClr_i;
    logic           FifoWriteEn_o;
    logic           FifoReadEn_o;
    logic           AxisValid_o;
    logic           AxisLast_o;
    logic           Overflow_o;
    logic           Busy_o;
    logic [CW-1:0]  FrameCnt_o;
`ifdef FIFO_ADC_DROP_CNT_EN
    logic [CW-1:0]  DropCnt_o;
`endif

    fifo_adc_stream_ctrl #(.FRAME_LEN_W(FLW), .CNT_W(CW)) dut (
        .Clk_i(Clk_i),
        .Rst_n_i(Rst_n_i),
        .Enable_i(Enable_i),
        .FrameLen_i(FrameLen_i),
        .AdcValid_i(AdcValid_i),
        .FifoFull_i(FifoFull_i),
        .FifoEmpty_i(FifoEmpty_i),
        .AxisReady_i(AxisReady_i),
        .OvfClr_i(OvfClr_i),
        .FifoWriteEn_o(FifoWriteEn_o),
        .FifoReadEn_o(FifoReadEn_o),
        .AxisValid_o(AxisValid_o),
        .AxisLast_o(AxisLast_o),
        .Overflow_o(Overflow_o),
        .Busy_o(Busy_o),
        .FrameCnt_o(FrameCnt_o)
`ifdef FIFO_ADC_DROP_CNT_EN
        ,
        .DropCnt_o(DropCnt_o)
`endif
    );

    always #5 Clk_i = ~Clk_i;

    int n_cmp = 0;
    int n_err = 0;
    int n_beats = 0;
    int n_last = 0;
    int tb_len = 1;
    int wr_idx = 0;
    int fifo_cnt = 0;
    bit sb[$];
    logic s_we = 1'b0;
    logic s_re = 1'b0;
    logic r_empty;
    logic r_full;
    logic force_full = 1'b0;
    logic rdy_tog = 1'b0;

    assign FifoEmpty_i = r_empty;
    assign FifoFull_i  = r_full | force_full;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // FWFT FIFO model: occupancy only, updated from enables captured mid-cycle.
    always @(posedge Clk_i) begin
        if (!Rst_n_i) begin
            fifo_cnt = 0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            fifo_cnt = fifo_cnt + int'(s_we) - int'(s_re);
            r_empty <= (fifo_cnt == 0);
            r_full  <= (fifo_cnt >= DEPTH);
        end
    end

    always @(negedge Clk_i) begin
        s_we = FifoWriteEn_o;
        s_re = FifoReadEn_o;
        if (Rst_n_i) begin
            chk("tvalid", AxisValid_o, !FifoEmpty_i);
            chk("rd_en", FifoReadEn_o, !FifoEmpty_i && AxisReady_i);
            if (FifoReadEn_o) begin
                n_beats++;
                if (AxisLast_o)
                    n_last++;
                if (sb.size() == 0)
                    chk("beat_unexpected", 1, 0);
                else
                    chk("tlast", AxisLast_o, sb.pop_front());
            end else if (!AxisValid_o) begin
                chk("tlast_idle", AxisLast_o, 0);
            end
        end
    end

    task automatic step(input logic en, input logic valid, input logic exp_we);
        Enable_i   = en;
        AdcValid_i = valid;
        if (rdy_tog)
            AxisReady_i = ~AxisReady_i;
        @(negedge Clk_i);
        chk("wr_en", FifoWriteEn_o, exp_we);
        if (exp_we) begin
            sb.push_back((wr_idx % tb_len) == tb_len - 1);
            wr_idx++;
        end
        @(posedge Clk_i);
        #1;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 300; k++) begin
            if (FifoEmpty_i && sb.size() == 0)
                break;
            if (rdy_tog)
                AxisReady_i = ~AxisReady_i;
            @(posedge Clk_i);
            #1;
        end
        chk("drain_done", k < 300, 1);
        chk("busy_idle", Busy_o, 0);
    endtask

    task automatic begin_frame(input logic [FLW-1:0] len, input int eff);
        FrameLen_i = len;
        tb_len = eff;
        wr_idx = 0;
        step(1'b1, 1'b0, 1'b0);
    endtask

    int b0;
    int l0;

    initial begin
        Rst_n_i     = 1'b0;
        Enable_i    = 1'b1;
        AdcValid_i  = 1'b1;
        FrameLen_i  = 16'd4;
        AxisReady_i = 1'b1;
        OvfClr_i    = 1'b0;

        // reset with capture requested
        repeat (3) @(posedge Clk_i);
        @(negedge Clk_i);
        chk("rst_wr_en", FifoWriteEn_o, 0);
        chk("rst_rd_en", FifoReadEn_o, 0);
        chk("rst_tvalid", AxisValid_o, 0);
        chk("rst_tlast", AxisLast_o, 0);
        chk("rst_ovf", Overflow_o, 0);
        chk("rst_busy", Busy_o, 0);
        chk("rst_framecnt", FrameCnt_o, 0);
        @(posedge Clk_i);
        #1;
        Rst_n_i = 1'b1;

        // first write one cycle after CAPTURE entry; 12 samples at L=4
        tb_len = 4;
        wr_idx = 0;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++)
            step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        wait_drain();
        chk("t2_framecnt", FrameCnt_o, 3);
        chk("t2_beats", n_beats, 12);
        chk("t2_lasts", n_last, 3);

        // stop mid-frame at L=8; length changes while active are ignored
        b0 = n_beats;
        l0 = n_last;
        begin_frame(16'd8, 8);
        FrameLen_i = 16'd2;
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_busy_stopping", Busy_o, 1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        wait_drain();
        chk("t3_framecnt", FrameCnt_o, 1);
        chk("t3_beats", n_beats - b0, 8);
        chk("t3_lasts", n_last - l0, 1);

        // overflow: two drops mid-frame, then set/clear collision
        l0 = n_last;
        begin_frame(16'd4, 4);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("t4_ovf_before", Overflow_o, 0);
        force_full = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk("t4_ovf_set", Overflow_o, 1);
        step(1'b1, 1'b1, 1'b0);
        force_full = 1'b0;
`ifdef FIFO_ADC_DROP_CNT_EN
        chk("t4_dropcnt", DropCnt_o, 2);
`endif
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        force_full = 1'b1;
        OvfClr_i = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        OvfClr_i = 1'b0;
        force_full = 1'b0;
        chk("t4_ovf_set_wins", Overflow_o, 1);
`ifdef FIFO_ADC_DROP_CNT_EN
        chk("t4_dropcnt_clr", DropCnt_o, 0);
`endif
        OvfClr_i = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        OvfClr_i = 1'b0;
        chk("t4_ovf_clr", Overflow_o, 0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        wait_drain();
        chk("t4_framecnt", FrameCnt_o, 2);
        chk("t4_lasts", n_last - l0, 2);

        // backpressure: TREADY toggling, L=3
        b0 = n_beats;
        l0 = n_last;
        rdy_tog = 1'b1;
        begin_frame(16'd3, 3);
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        wait_drain();
        rdy_tog = 1'b0;
        AxisReady_i = 1'b1;
        chk("t5_framecnt", FrameCnt_o, 2);
        chk("t5_beats", n_beats - b0, 6);
        chk("t5_lasts", n_last - l0, 2);

        // re-enable while 5 words are queued; new length 0 acts as 1
        AxisReady_i = 1'b0;
        begin_frame(16'd5, 5);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        FrameLen_i = 16'd0;
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0);
        chk("t6_busy_undrained", Busy_o, 1);
        chk("t6_framecnt_held", FrameCnt_o, 1);
        AxisReady_i = 1'b1;
        l0 = n_last;
        begin
            int k;
            for (k = 0; k < 50; k++) begin
                if (FifoEmpty_i)
                    break;
                step(1'b1, 1'b0, 1'b0);
            end
            chk("t6_drain_done", k < 50, 1);
        end
        chk("t6_lasts_old", n_last - l0, 1);
        tb_len = 1;
        wr_idx = 0;
        step(1'b1, 1'b0, 1'b0);
        chk("t6_framecnt_cleared", FrameCnt_o, 0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        wait_drain();
        chk("t6_framecnt", FrameCnt_o, 3);
        chk("t6_lasts_new", n_last - l0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
